// File: rtl/game_pkg.sv
// Shared types and default playfield constants for the game blocks.
// Holds the safe_zone FSM state enum and the default screen geometry.
package game_pkg;

    typedef enum logic [1:0] {
        GEN  = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } sz_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/safe_zone_if.sv
// Handshake bundle between game_status (master) and safe_zone (slave).
// Inputs: regenerate pulse, run level, frame tick, player position.
// Outputs: ready, round-end pulse, win flag, zone corner, frames left.
interface safe_zone_if #(
    parameter int COORD_W = 10,
    parameter int FRAME_W = 8
);

    logic               i_regenerate_level;
    logic               i_game_running;
    logic               i_frame_tick;
    logic [COORD_W-1:0] i_player_x;
    logic [COORD_W-1:0] i_player_y;

    logic               o_ready;
    logic               o_round_ended;
    logic               o_is_win;
    logic [COORD_W-1:0] o_zone_x;
    logic [COORD_W-1:0] o_zone_y;
    logic [FRAME_W-1:0] o_frames_left;

    modport master (
        output i_regenerate_level,
        output i_game_running,
        output i_frame_tick,
        output i_player_x,
        output i_player_y,
        input  o_ready,
        input  o_round_ended,
        input  o_is_win,
        input  o_zone_x,
        input  o_zone_y,
        input  o_frames_left
    );

    modport slave (
        input  i_regenerate_level,
        input  i_game_running,
        input  i_frame_tick,
        input  i_player_x,
        input  i_player_y,
        output o_ready,
        output o_round_ended,
        output o_is_win,
        output o_zone_x,
        output o_zone_y,
        output o_frames_left
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
// Ports: clk, rst_n (sync, active-low, loads SEED), o_value[15:0].
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_value
);

    logic fb;

    assign fb = o_value[15] ^ o_value[13] ^ o_value[12] ^ o_value[10];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_value <= SEED;
        end else begin
            o_value <= {o_value[14:0], fb};
        end
    end

endmodule

// File: rtl/safe_zone.sv
// Safe-zone generator and round referee for game_status.
// Ports: clk, rst_n (sync, active-low) and safe_zone_if.slave bus
// carrying regenerate/run/tick/player inputs and the zone/round outputs.
module safe_zone #(
    parameter int          SCREEN_W     = game_pkg::SCREEN_W,
    parameter int          SCREEN_H     = game_pkg::SCREEN_H,
    parameter int          COORD_W      = game_pkg::COORD_W,
    parameter int          ZONE_SIZE    = 64,
    parameter int          ROUND_FRAMES = 180,
    parameter int          MAX_TRIES    = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    safe_zone_if.slave   bus
);

    import game_pkg::sz_state_t;
    import game_pkg::GEN;
    import game_pkg::PLAY;
    import game_pkg::DONE;

    localparam int FRAME_W = $clog2(ROUND_FRAMES + 1);
    localparam int TRY_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int CW1     = COORD_W + 1;

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED =
        (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

    localparam logic [CW1-1:0] X_MAX  = CW1'(SCREEN_W - ZONE_SIZE);
    localparam logic [CW1-1:0] Y_MAX  = CW1'(SCREEN_H - ZONE_SIZE);
    localparam logic [CW1-1:0] Z_SPAN = CW1'(ZONE_SIZE - 1);

    localparam logic [TRY_W-1:0]   LAST_TRY    = TRY_W'(MAX_TRIES - 1);
    localparam logic [FRAME_W-1:0] FRAMES_INIT = FRAME_W'(ROUND_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_ONE   = FRAME_W'(1);

    sz_state_t state;
    sz_state_t state_nxt;

    logic [15:0]        lfsr;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               x_ok;
    logic               y_ok;
    logic               give_up;
    logic [COORD_W-1:0] gen_x;
    logic [COORD_W-1:0] gen_y;

    logic               accept;
    logic               frame_step;
    logic               expire;

    logic [CW1-1:0]     px_e;
    logic [CW1-1:0]     py_e;
    logic [CW1-1:0]     zx_e;
    logic [CW1-1:0]     zy_e;
    logic               in_zone;

    logic [TRY_W-1:0]   tries;
    logic [FRAME_W-1:0] frames;
    logic               ready;
    logic               ended;
    logic               win;
    logic [COORD_W-1:0] zone_x;
    logic [COORD_W-1:0] zone_y;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_value(lfsr)
    );

    // Candidate corner: low bits give X, high bits give Y.
    assign cx = lfsr[COORD_W-1:0];
    assign cy = lfsr[15 -: COORD_W];

    assign x_ok    = {1'b0, cx} <= X_MAX;
    assign y_ok    = {1'b0, cy} <= Y_MAX;
    assign give_up = (tries == LAST_TRY);

    // Clamp only the failing axis; a passing axis keeps its candidate.
    assign gen_x = x_ok ? cx : X_MAX[COORD_W-1:0];
    assign gen_y = y_ok ? cy : Y_MAX[COORD_W-1:0];

    // Judge in COORD_W+1 bits so zone_x + ZONE_SIZE-1 never wraps.
    assign px_e = {1'b0, bus.i_player_x};
    assign py_e = {1'b0, bus.i_player_y};
    assign zx_e = {1'b0, zone_x};
    assign zy_e = {1'b0, zone_y};

    assign in_zone = (px_e >= zx_e) && (px_e <= zx_e + Z_SPAN) &&
                     (py_e >= zy_e) && (py_e <= zy_e + Z_SPAN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= GEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_regenerate_level) begin
            state_nxt = GEN;
        end else begin
            unique case (state)
                GEN:     if (accept) state_nxt = PLAY;
                PLAY:    if (expire) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = GEN;
            endcase
        end
    end

    always_comb begin
        accept     = 1'b0;
        frame_step = 1'b0;
        expire     = 1'b0;
        unique case (state)
            GEN: begin
                accept = (x_ok && y_ok) || give_up;
            end
            PLAY: begin
                frame_step = bus.i_frame_tick && bus.i_game_running;
                expire     = frame_step && (frames == FRAME_ONE);
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Regenerate outranks every other event, including the final tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tries  <= '0;
            frames <= FRAMES_INIT;
            ready  <= 1'b0;
            ended  <= 1'b0;
            win    <= 1'b0;
            zone_x <= '0;
            zone_y <= '0;
        end else begin
            ended <= 1'b0;
            if (bus.i_regenerate_level) begin
                tries  <= '0;
                frames <= FRAMES_INIT;
                ready  <= 1'b0;
                win    <= 1'b0;
            end else if (accept) begin
                tries  <= '0;
                frames <= FRAMES_INIT;
                ready  <= 1'b1;
                zone_x <= gen_x;
                zone_y <= gen_y;
            end else if (state == GEN) begin
                tries <= tries + 1'b1;
            end else if (expire) begin
                frames <= '0;
                ready  <= 1'b0;
                ended  <= 1'b1;
                win    <= in_zone;
            end else if (frame_step) begin
                frames <= frames - 1'b1;
            end
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_round_ended = ended;
    assign bus.o_is_win      = win;
    assign bus.o_zone_x      = zone_x;
    assign bus.o_zone_y      = zone_y;
    assign bus.o_frames_left = frames;

endmodule

// File: tb/tb_safe_zone.sv
// Self-checking bench for safe_zone: behavioural model plus directed
// scenarios (reset, win, lose, pause, clamp, regenerate collision).
module tb_safe_zone;

    localparam int CW   = 10;
    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int ZS   = 64;
    localparam int RF   = 3;
    localparam int MT   = 8;
    localparam int FW   = $clog2(RF + 1);
    localparam int XMAX = SW - ZS;
    localparam int YMAX = SH - ZS;

    localparam int P_GEN  = 0;
    localparam int P_PLAY = 1;
    localparam int P_DONE = 2;

    typedef struct {
        int   lfsr;
        int   phase;
        int   tries;
        int   zx;
        int   zy;
        int   frames;
        logic ready;
        logic ended;
        logic win;
    } model_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   chk_en = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;
    model_t m;

    always #5 clk = ~clk;

    safe_zone_if #(.COORD_W(CW), .FRAME_W(FW)) bus ();
    safe_zone_if #(.COORD_W(CW), .FRAME_W(FW)) bus_b ();

    safe_zone #(
        .SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW), .ZONE_SIZE(ZS),
        .ROUND_FRAMES(RF), .MAX_TRIES(MT), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    safe_zone #(
        .SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW), .ZONE_SIZE(ZS),
        .ROUND_FRAMES(RF), .MAX_TRIES(MT), .LFSR_SEED(16'hFFFF)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) & 32'hFFFF) | fb;
    endfunction

    function automatic logic inside_zone(input int px, input int py,
                                         input int zx, input int zy);
        return (px >= zx) && (px < zx + ZS) && (py >= zy) && (py < zy + ZS);
    endfunction

    // One clock of the game rules, in plain integer arithmetic.
    function automatic model_t model_next(input model_t s, input logic rst,
                                          input logic regen, input logic run,
                                          input logic tick, input int px,
                                          input int py);
        model_t n;
        int cx;
        int cy;
        n = s;
        if (!rst) begin
            n.lfsr = 16'hACE1; n.phase = P_GEN; n.tries = 0;
            n.zx = 0; n.zy = 0; n.frames = RF;
            n.ready = 1'b0; n.ended = 1'b0; n.win = 1'b0;
            return n;
        end
        n.lfsr  = lfsr_next(s.lfsr);
        n.ended = 1'b0;
        cx = s.lfsr % 1024;
        cy = s.lfsr / 64;
        if (regen) begin
            n.phase = P_GEN; n.tries = 0; n.frames = RF;
            n.ready = 1'b0; n.win = 1'b0;
        end else if (s.phase == P_GEN) begin
            if ((cx <= XMAX && cy <= YMAX) || s.tries == MT - 1) begin
                n.zx = (cx > XMAX) ? XMAX : cx;
                n.zy = (cy > YMAX) ? YMAX : cy;
                n.phase = P_PLAY; n.tries = 0; n.frames = RF;
                n.ready = 1'b1;
            end else begin
                n.tries = s.tries + 1;
            end
        end else if (s.phase == P_PLAY && run && tick) begin
            n.frames = s.frames - 1;
            if (n.frames == 0) begin
                n.phase = P_DONE; n.ready = 1'b0; n.ended = 1'b1;
                n.win = inside_zone(px, py, s.zx, s.zy);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst_n, bus.i_regenerate_level,
                        bus.i_game_running, bus.i_frame_tick,
                        int'(bus.i_player_x), int'(bus.i_player_y));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("ready", bus.o_ready, m.ready);
            chk1("round_ended", bus.o_round_ended, m.ended);
            chk1("is_win", bus.o_is_win, m.win);
            if (m.ready || m.ended)
                chkn("frames_left", 32'(bus.o_frames_left), 32'(m.frames));
            if (m.phase != P_GEN) begin
                chkn("zone_x", 32'(bus.o_zone_x), 32'(m.zx));
                chkn("zone_y", 32'(bus.o_zone_y), 32'(m.zy));
            end
        end
    end

    // Seed FFFF keeps the top ten bits near 1023 for the first eight
    // steps, so every attempt fails and the clamp lands on (576,416).
    initial begin : clamp_proc
        int nb;
        bus_b.i_regenerate_level = 1'b0;
        bus_b.i_game_running = 1'b0;
        bus_b.i_frame_tick = 1'b0;
        bus_b.i_player_x = '0;
        bus_b.i_player_y = '0;
        @(posedge rst_n);
        nb = 0;
        while (!bus_b.o_ready && nb < MT + 2) begin
            @(negedge clk);
            nb++;
        end
        chkn("clamp_cycles", nb, MT);
        chkn("clamp_x", 32'(bus_b.o_zone_x), 576);
        chkn("clamp_y", 32'(bus_b.o_zone_y), 416);
        chkn("clamp_frames", 32'(bus_b.o_frames_left), RF);
    end

    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (!bus.o_ready && n < MT + 1) begin
            @(negedge clk);
            n++;
        end
        chk1(name, bus.o_ready, 1'b1);
    endtask

    task automatic regen_pulse();
        bus.i_regenerate_level = 1'b1;
        @(negedge clk);
        bus.i_regenerate_level = 1'b0;
    endtask

    task automatic tick_once();
        bus.i_frame_tick = 1'b1;
        @(negedge clk);
        bus.i_frame_tick = 1'b0;
    endtask

    task automatic set_player(input int x, input int y);
        bus.i_player_x = CW'(x < 0 ? 0 : x);
        bus.i_player_y = CW'(y < 0 ? 0 : y);
    endtask

    initial begin : stim
        int n;
        int px;
        int py;
        bus.i_regenerate_level = 1'b0;
        bus.i_game_running = 1'b0;
        bus.i_frame_tick = 1'b0;
        set_player(0, 0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        chk1("rst_ready", bus.o_ready, 1'b0);
        chk1("rst_ended", bus.o_round_ended, 1'b0);
        chk1("rst_win", bus.o_is_win, 1'b0);
        chkn("rst_zone_x", 32'(bus.o_zone_x), 0);
        chkn("rst_zone_y", 32'(bus.o_zone_y), 0);
        chkn("rst_frames", 32'(bus.o_frames_left), RF);

        // ACE1 gives (225,691): rejected. Next 59C3 gives (451,359).
        rst_n = 1'b1;
        wait_ready("reset_start", n);
        chkn("reset_start_cycles", n, 2);
        chkn("reset_zone_x", 32'(bus.o_zone_x), 451);
        chkn("reset_zone_y", 32'(bus.o_zone_y), 359);

        bus.i_game_running = 1'b1;
        set_player(451 + 63, 359);
        tick_once();
        chkn("win_frames2", 32'(bus.o_frames_left), 2);
        tick_once();
        chkn("win_frames1", 32'(bus.o_frames_left), 1);
        tick_once();
        chk1("win_ended", bus.o_round_ended, 1'b1);
        chk1("win_flag", bus.o_is_win, 1'b1);
        chk1("win_ready_low", bus.o_ready, 1'b0);
        @(negedge clk);
        chk1("win_pulse_one", bus.o_round_ended, 1'b0);
        chk1("win_held", bus.o_is_win, 1'b1);

        regen_pulse();
        chk1("regen_clr_win", bus.o_is_win, 1'b0);
        chk1("regen_clr_ready", bus.o_ready, 1'b0);
        wait_ready("lose_ready", n);
        set_player(m.zx + 64, m.zy);
        repeat (3) tick_once();
        chk1("lose_ended", bus.o_round_ended, 1'b1);
        chk1("lose_flag", bus.o_is_win, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk1("lose_held", bus.o_is_win, 1'b0);
        end

        regen_pulse();
        wait_ready("pause_ready", n);
        set_player(m.zx, m.zy);
        tick_once();
        chkn("pause_start", 32'(bus.o_frames_left), 2);
        bus.i_game_running = 1'b0;
        repeat (10) begin
            tick_once();
            chkn("pause_hold", 32'(bus.o_frames_left), 2);
        end
        bus.i_game_running = 1'b1;
        tick_once();
        chkn("pause_resume", 32'(bus.o_frames_left), 1);
        tick_once();
        chk1("pause_ended", bus.o_round_ended, 1'b1);
        chk1("pause_win", bus.o_is_win, 1'b1);

        regen_pulse();
        wait_ready("coll_ready", n);
        repeat (2) tick_once();
        bus.i_regenerate_level = 1'b1;
        tick_once();
        bus.i_regenerate_level = 1'b0;
        chk1("coll_no_end", bus.o_round_ended, 1'b0);
        chk1("coll_ready_low", bus.o_ready, 1'b0);
        wait_ready("coll_rerise", n);
        chkn("coll_frames", 32'(bus.o_frames_left), RF);

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if (m.phase == P_DONE)
                bus.i_regenerate_level = ($urandom_range(0, 3) == 0);
            else
                bus.i_regenerate_level = ($urandom_range(0, 49) == 0);
            bus.i_game_running = ($urandom_range(0, 7) != 0);
            bus.i_frame_tick = ($urandom_range(0, 1) == 1);
            px = m.zx + int'($urandom_range(0, 71)) - 4;
            py = m.zy + int'($urandom_range(0, 71)) - 4;
            set_player(px, py);
            @(negedge clk);
        end

        rst_n = 1'b1;
        bus.i_regenerate_level = 1'b0;
        bus.i_frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
